// File: rtl/aibnd_dcc_pkg.sv
// Shared definitions for the DCC calibration sequencer.
//   dcc_cal_state_t : sequencer FSM states
//   code_mid()      : mid-scale DCC code for a given code width
//   DEF_*           : default parameter values
package aibnd_dcc_pkg;

    localparam int unsigned DEF_NUM_CH     = 2;
    localparam int unsigned DEF_CODE_W     = 5;
    localparam int unsigned DEF_SETTLE_CYC = 4;
    localparam int unsigned DEF_TRACK_INTV = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_NEXT_CH,
        ST_DONE,
        ST_TRACK
    } dcc_cal_state_t;

    // Mid-scale code: only the MSB set. This is also the first SAR trial value.
    function automatic int unsigned code_mid(input int unsigned code_w);
        return 32'd1 << (code_w - 1);
    endfunction

endpackage

// File: rtl/aibnd_dcc_cal_seq_sync2.sv
// Parametrised-width two-flop synchronizer, async active-low reset to 0.
//   clk   : destination clock
//   rst_n : async active-low reset
//   d     : asynchronous input bits
//   q     : synchronized bits (2-cycle latency)
module aibnd_dcc_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/aibnd_dcc_cal_seq.sv
// Duty-cycle-correction calibration sequencer.
// Calibrates NUM_CH DCC delay lines one at a time with a SAR search on the
// synchronized duty-cycle-detector result, then optionally tracks drift.
//   clk_dcd     : calibration clock
//   nrst        : async active-low reset
//   dcc_req     : calibration request (async, level)
//   rb_dcc_en   : enable; 0 forces IDLE
//   rb_dcc_byp  : bypass; codes forced mid-scale, done follows request
//   rb_cont_cal : track drift after lock
//   dcd_up      : per-channel DCD result (async); 1 = raise code
//   dcc_code    : packed codes, channel c at [c*CODE_W +: CODE_W]
//   dcc_done    : calibration complete / bypass acknowledge
//   cal_busy    : search in progress
//   cal_ch      : channel under calibration/tracking
module aibnd_dcc_cal_seq
    import aibnd_dcc_pkg::*;
#(
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned CODE_W     = DEF_CODE_W,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int unsigned TRACK_INTV = DEF_TRACK_INTV
) (
    input  logic                     clk_dcd,
    input  logic                     nrst,
    input  logic                     dcc_req,
    input  logic                     rb_dcc_en,
    input  logic                     rb_dcc_byp,
    input  logic                     rb_cont_cal,
    input  logic [NUM_CH-1:0]        dcd_up,
    output logic [NUM_CH*CODE_W-1:0] dcc_code,
    output logic                     dcc_done,
    output logic                     cal_busy,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cal_ch
);

    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BIT_W   = $clog2(CODE_W);
    localparam int unsigned CNT_MAX = (SETTLE_CYC > TRACK_INTV) ? SETTLE_CYC : TRACK_INTV;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [CODE_W-1:0] MID      = CODE_W'(code_mid(CODE_W));
    localparam logic [BIT_W-1:0]  BIT_TOP  = BIT_W'(CODE_W - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0]  SET_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  TRK_LAST = CNT_W'(TRACK_INTV - 1);

    logic              req_s;
    logic [NUM_CH-1:0] dcd_s;

    dcc_cal_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [BIT_W-1:0]  bit_q,   bit_d;
    logic [CH_W-1:0]   ch_q,    ch_d;
    logic [CODE_W-1:0] code_q [NUM_CH];
    logic [CODE_W-1:0] code_d [NUM_CH];
    logic              done_q,  done_d;
    logic              busy_q,  busy_d;

    logic              abort;
    logic [CH_W-1:0]   ch_nxt;

    aibnd_dcc_sync2 #(.WIDTH(1)) u_req_sync (
        .clk   (clk_dcd),
        .rst_n (nrst),
        .d     (dcc_req),
        .q     (req_s)
    );

    aibnd_dcc_sync2 #(.WIDTH(NUM_CH)) u_dcd_sync (
        .clk   (clk_dcd),
        .rst_n (nrst),
        .d     (dcd_up),
        .q     (dcd_s)
    );

    // Bypass is folded into abort so that asserting it mid-search returns to IDLE.
    assign abort  = !rb_dcc_en || !req_s || rb_dcc_byp;
    assign ch_nxt = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        ch_d    = ch_q;
        code_d  = code_q;
        done_d  = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ch_d    = '0;
            bit_d   = BIT_TOP;
            if (rb_dcc_en && rb_dcc_byp) begin
                for (int unsigned c = 0; c < NUM_CH; c++) code_d[c] = MID;
                done_d = req_s;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d   = ST_SETTLE;
                    ch_d      = '0;
                    cnt_d     = '0;
                    bit_d     = BIT_TOP;
                    code_d[0] = MID;
                end
                ST_SETTLE: begin
                    if (cnt_q == SET_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SAMPLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    code_d[ch_q][bit_q] = dcd_s[ch_q];
                    if (bit_q != '0) begin
                        code_d[ch_q][bit_q - BIT_W'(1)] = 1'b1;
                        bit_d   = bit_q - BIT_W'(1);
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_NEXT_CH;
                    end
                end
                ST_NEXT_CH: begin
                    ch_d = ch_nxt;
                    if (ch_q == CH_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        code_d[ch_nxt] = MID;
                        bit_d          = BIT_TOP;
                        cnt_d          = '0;
                        state_d        = ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    done_d = 1'b1;
                    if (rb_cont_cal) begin
                        cnt_d   = '0;
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    done_d = 1'b1;
                    if (!rb_cont_cal) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else if (cnt_q == TRK_LAST) begin
                        cnt_d = '0;
                        ch_d  = ch_nxt;
                        // Saturating single-LSB step toward the DCD verdict.
                        if (dcd_s[ch_q]) begin
                            if (code_q[ch_q] != '1) code_d[ch_q] = code_q[ch_q] + CODE_W'(1);
                        end else begin
                            if (code_q[ch_q] != '0) code_d[ch_q] = code_q[ch_q] - CODE_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE) || (state_d == ST_NEXT_CH);
    end

    always_ff @(posedge clk_dcd or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= BIT_TOP;
            ch_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) code_q[c] <= MID;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            ch_q    <= ch_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            for (int unsigned c = 0; c < NUM_CH; c++) code_q[c] <= code_d[c];
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_code
        assign dcc_code[c*CODE_W +: CODE_W] = code_q[c];
    end

    assign dcc_done = done_q;
    assign cal_busy = busy_q;
    assign cal_ch   = ch_q;

endmodule

// File: tb/tb_aibnd_dcc_cal_seq.sv
module tb_aibnd_dcc_cal_seq;

    localparam int unsigned NUM_CH     = 2;
    localparam int unsigned CODE_W     = 5;
    localparam int unsigned SETTLE_CYC = 4;
    localparam int unsigned TRACK_INTV = 16;

    logic        clk_dcd = 1'b0;
    logic        nrst;
    logic        dcc_req;
    logic        rb_dcc_en;
    logic        rb_dcc_byp;
    logic        rb_cont_cal;
    logic [1:0]  dcd_up;
    logic [9:0]  dcc_code;
    logic        dcc_done;
    logic        cal_busy;
    logic [0:0]  cal_ch;

    // DCD plant: fixed pattern or threshold model (up while code < threshold).
    logic        dcd_mode;
    logic [1:0]  dcd_fix;

    typedef struct {
        int         lat;
        logic [9:0] code;
    } exp_t;
    exp_t sb[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk_dcd = ~clk_dcd;

    always_comb begin
        if (dcd_mode)
            dcd_up = {(dcc_code[9:5] < 5'd7), (dcc_code[4:0] < 5'd19)};
        else
            dcd_up = dcd_fix;
    end

    aibnd_dcc_cal_seq #(
        .NUM_CH     (NUM_CH),
        .CODE_W     (CODE_W),
        .SETTLE_CYC (SETTLE_CYC),
        .TRACK_INTV (TRACK_INTV)
    ) dut (
        .clk_dcd     (clk_dcd),
        .nrst        (nrst),
        .dcc_req     (dcc_req),
        .rb_dcc_en   (rb_dcc_en),
        .rb_dcc_byp  (rb_dcc_byp),
        .rb_cont_cal (rb_cont_cal),
        .dcd_up      (dcd_up),
        .dcc_code    (dcc_code),
        .dcc_done    (dcc_done),
        .cal_busy    (cal_busy),
        .cal_ch      (cal_ch)
    );

    // Full calibration: expected result queued with the request, checked when done rises.
    task automatic run_cal(input logic [4:0] e0, input logic [4:0] e1);
        exp_t e;
        exp_t got;
        int   n;
        bit   seen;
        e.lat  = 55;
        e.code = {e1, e0};
        sb.push_back(e);
        @(negedge clk_dcd);
        dcc_req = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk_dcd);
            n++;
            @(negedge clk_dcd);
            if (dcc_done === 1'b1) seen = 1'b1;
        end
        got = sb.pop_front();
        chk_cnt++;
        if (!seen || (n - 1) != got.lat)
            $display("FAIL cal_latency: got %0d cycles (done seen=%0b), expected %0d", n - 1, seen, got.lat);
        else
            pass_cnt++;
        chk_cnt++;
        if (dcc_code !== got.code)
            $display("FAIL cal_codes: got ch1=%0d ch0=%0d, expected ch1=%0d ch0=%0d",
                     dcc_code[9:5], dcc_code[4:0], got.code[9:5], got.code[4:0]);
        else
            pass_cnt++;
    endtask

    task automatic drop_req();
        @(negedge clk_dcd);
        dcc_req = 1'b0;
        repeat (5) @(negedge clk_dcd);
    endtask

    task automatic test_reset();
        nrst        = 1'b0;
        dcc_req     = 1'b0;
        rb_dcc_en   = 1'b1;
        rb_dcc_byp  = 1'b0;
        rb_cont_cal = 1'b0;
        dcd_mode    = 1'b0;
        dcd_fix     = 2'b00;
        repeat (3) @(negedge clk_dcd);
        chk_cnt++;
        if (dcc_code !== 10'h210 || dcc_done !== 1'b0 || cal_busy !== 1'b0 || cal_ch !== 1'b0)
            $display("FAIL reset_state: code=%h done=%b busy=%b ch=%b, expected code=210 done=0 busy=0 ch=0",
                     dcc_code, dcc_done, cal_busy, cal_ch);
        else
            pass_cnt++;
        nrst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_dcd);
            chk_cnt++;
            if (dcc_code !== 10'h210 || dcc_done !== 1'b0 || cal_busy !== 1'b0)
                $display("FAIL idle_cycle_%0d: code=%h done=%b busy=%b, expected code=210 done=0 busy=0",
                         i, dcc_code, dcc_done, cal_busy);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_saturate_search();
        dcd_fix = 2'b11;
        run_cal(5'd31, 5'd31);
        drop_req();
        dcd_fix = 2'b00;
        run_cal(5'd0, 5'd0);
        drop_req();
    endtask

    task automatic test_converge();
        logic [9:0] snap;
        dcd_mode = 1'b1;
        run_cal(5'd18, 5'd6);
        snap = 10'h0;
        snap[4:0] = 5'd18;
        snap[9:5] = 5'd6;
        repeat (50) @(negedge clk_dcd);
        chk_cnt++;
        if (dcc_code !== snap || dcc_done !== 1'b1 || cal_busy !== 1'b0)
            $display("FAIL hold_after_done: code=%h done=%b busy=%b, expected code=%h done=1 busy=0",
                     dcc_code, dcc_done, cal_busy, snap);
        else
            pass_cnt++;
        drop_req();
        dcd_mode = 1'b0;
    endtask

    task automatic test_track();
        logic [4:0] m [2];
        int         mch;
        logic [1:0] dir;
        logic [9:0] snap;
        dcd_fix = 2'b01;
        run_cal(5'd31, 5'd0);
        m[0] = 5'd31;
        m[1] = 5'd0;
        mch  = 0;
        @(negedge clk_dcd);
        rb_cont_cal = 1'b1;
        for (int t = 1; t <= 160; t++) begin
            @(posedge clk_dcd);
            if (t >= 17 && ((t - 17) % 16) == 0) begin
                dir = (t < 73) ? 2'b01 : 2'b10;
                if (dir[mch]) begin
                    if (m[mch] != 5'd31) m[mch] = m[mch] + 5'd1;
                end else begin
                    if (m[mch] != 5'd0) m[mch] = m[mch] - 5'd1;
                end
                mch = 1 - mch;
            end
            @(negedge clk_dcd);
            chk_cnt++;
            if (dcc_code !== {m[1], m[0]} || cal_ch !== 1'(mch) || dcc_done !== 1'b1)
                $display("FAIL track_t%0d: ch1=%0d ch0=%0d cal_ch=%0d done=%b, expected ch1=%0d ch0=%0d cal_ch=%0d done=1",
                         t, dcc_code[9:5], dcc_code[4:0], cal_ch, dcc_done, m[1], m[0], mch);
            else
                pass_cnt++;
            if (t == 73) dcd_fix = 2'b10;
        end
        rb_cont_cal = 1'b0;
        repeat (3) @(negedge clk_dcd);
        snap = dcc_code;
        repeat (40) @(negedge clk_dcd);
        chk_cnt++;
        if (dcc_code !== snap || dcc_code !== {m[1], m[0]} || dcc_done !== 1'b1)
            $display("FAIL track_stop_hold: code=%h done=%b, expected code=%h done=1", dcc_code, dcc_done, {m[1], m[0]});
        else
            pass_cnt++;
        drop_req();
    endtask

    task automatic test_abort();
        dcd_mode = 1'b1;
        @(negedge clk_dcd);
        dcc_req = 1'b1;
        for (int n = 1; n <= 31; n++) begin
            @(posedge clk_dcd);
            @(negedge clk_dcd);
        end
        chk_cnt++;
        if (cal_busy !== 1'b1 || cal_ch !== 1'b1 || dcc_done !== 1'b0)
            $display("FAIL abort_pre: busy=%b ch=%b done=%b, expected busy=1 ch=1 done=0", cal_busy, cal_ch, dcc_done);
        else
            pass_cnt++;
        dcc_req = 1'b0;
        repeat (3) @(negedge clk_dcd);
        chk_cnt++;
        if (cal_busy !== 1'b0 || cal_ch !== 1'b0 || dcc_done !== 1'b0)
            $display("FAIL abort_idle: busy=%b ch=%b done=%b, expected busy=0 ch=0 done=0", cal_busy, cal_ch, dcc_done);
        else
            pass_cnt++;
        // ch1 holds its MSB trial: the SAMPLE coinciding with the abort must not write.
        chk_cnt++;
        if (dcc_code !== {5'd16, 5'd18})
            $display("FAIL abort_codes: ch1=%0d ch0=%0d, expected ch1=16 ch0=18", dcc_code[9:5], dcc_code[4:0]);
        else
            pass_cnt++;
        repeat (10) @(negedge clk_dcd);
        chk_cnt++;
        if (dcc_code !== {5'd16, 5'd18} || cal_busy !== 1'b0)
            $display("FAIL abort_frozen: code=%h busy=%b, expected code=%h busy=0", dcc_code, cal_busy, {5'd16, 5'd18});
        else
            pass_cnt++;
        run_cal(5'd18, 5'd6);
        drop_req();
        dcd_mode = 1'b0;
    endtask

    task automatic measure_done_edge(input logic req_val, input int exp_lat, input string nm);
        exp_t e;
        exp_t got;
        int   n;
        bit   seen;
        e.lat  = exp_lat;
        e.code = 10'h210;
        sb.push_back(e);
        @(negedge clk_dcd);
        dcc_req = req_val;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk_dcd);
            n++;
            @(negedge clk_dcd);
            if (dcc_done === req_val) seen = 1'b1;
        end
        got = sb.pop_front();
        chk_cnt++;
        if (!seen || n != got.lat || dcc_code !== got.code)
            $display("FAIL %s: latency=%0d (seen=%0b) code=%h, expected latency=%0d code=%h",
                     nm, n, seen, dcc_code, got.lat, got.code);
        else
            pass_cnt++;
    endtask

    task automatic test_bypass();
        int bad;
        @(negedge clk_dcd);
        rb_dcc_byp = 1'b1;
        repeat (2) @(negedge clk_dcd);
        chk_cnt++;
        if (dcc_code !== 10'h210 || dcc_done !== 1'b0)
            $display("FAIL byp_codes: code=%h done=%b, expected code=210 done=0", dcc_code, dcc_done);
        else
            pass_cnt++;
        measure_done_edge(1'b1, 3, "byp_rise");
        measure_done_edge(1'b0, 3, "byp_fall");
        measure_done_edge(1'b1, 3, "byp_rise2");
        @(negedge clk_dcd);
        rb_dcc_en = 1'b0;
        @(negedge clk_dcd);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_dcd);
            if (dcc_done !== 1'b0 || cal_busy !== 1'b0) bad++;
        end
        chk_cnt++;
        if (bad != 0)
            $display("FAIL en_off_done: %0d cycles with done/busy high, expected 0", bad);
        else
            pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_saturate_search();
        test_converge();
        test_track();
        test_abort();
        test_bypass();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
